reg_fifo: RTL
=============

Name: reg_fifo

Overview:
- Parametrised successor of the single load-enable register: a DEPTH-entry bank of WIDTH-bit registers organised as a synchronous first-word-fall-through FIFO.
- Buffers data between datapath stages that produce and consume at different rates.
- Adds occupancy count, full/empty/almost-full flags, a flush, and registered overflow/underflow error pulses.

Parameters:
- LENGTH, 8, data width in bits (≥1).
- DEPTH, 4, number of entries (≥2; not required to be a power of two).
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH).

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset; sampled on posedge clk only.
- flush  input  1  synchronous clear of queue state (not storage).
- inp  input  LENGTH  write data.
- push  input  1  write request.
- pop  input  1  read request.
- outp  output  LENGTH  head entry (fall-through); all zeros when empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ AF_LEVEL.
- count  output  $clog2(DEPTH+1)  current occupancy.
- ovf  output  1  one-cycle pulse: previous cycle had a rejected push.
- udf  output  1  one-cycle pulse: previous cycle had a rejected pop.

Behaviour:
- Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, all storage entries=0, ovf=udf=0. Resulting outputs: empty=1, full=0, almost_full=0, outp=0. rst overrides flush, push and pop.
- Flush (rst=0, flush=1): wr_ptr=rd_ptr=0, count=0, ovf=udf=0. Storage is not cleared. Concurrent push and pop are ignored and do not raise ovf/udf.
- Accept rules (rst=0, flush=0), evaluated on current-cycle state:
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok). When full, a simultaneous valid pop frees the slot, so both are accepted.
  - When empty, push+pop: push accepted, pop rejected. Data becomes visible on outp next cycle; udf pulses next cycle.
- On push_ok: mem[wr_ptr] <= inp; wr_ptr advances by 1, wrapping DEPTH-1 -> 0.
- On pop_ok: rd_ptr advances by 1, same wrap rule.
- count <= count + push_ok - pop_ok. Both accepted means count is unchanged.
- ovf <= push & !push_ok; udf <= pop & !pop_ok. Both are registered and high for exactly one cycle per rejected request.
- outp = empty ? 0 : mem[rd_ptr], combinational from registered state.
  - Write-to-outp latency: 1 cycle (data pushed at edge N appears after edge N).
  - Pop takes effect at the edge; the next head is visible after it.
- full, empty and almost_full are combinational decodes of the registered count. No combinational path from inp to outp.
- Rejected requests leave pointers, count and storage unchanged.
- The wrap must be correct for non-power-of-two DEPTH. Pointer width is $clog2(DEPTH), with a minimum of 1.

Test Plan:
1. Reset and idle (LENGTH=8, DEPTH=4): rst=1 for 2 cycles with push=1, inp=8'hAA -> after release count=0, empty=1, outp=8'h00, ovf=udf=0. Nothing stored.
2. Fill and drain: push 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles -> count 1,2,3,4; almost_full=1 at count=3; full=1 at 4. Then pop 4 cycles -> outp 11,22,33,44 in order; empty=1 and outp=00 after the last pop.
3. Overflow and underflow: when full, push 8'h55 with pop=0 -> ovf=1 for exactly one cycle, count stays 4, 8'h55 is never read. When empty, pop=1 -> udf=1 for one cycle, count stays 0.
4. Simultaneous push/pop:
   - Full with head 8'h11: push 8'h66 + pop -> count stays 4; later drain reads 22,33,44,66.
   - Empty: push 8'h77 + pop -> count=1, outp=8'h77, udf pulse.
5. Wrap-around with DEPTH=3: 10 alternating push/pop pairs with inp=0..9 -> outp sequence 0..9 in order; count never exceeds 1; pointers pass through 2 -> 0.
6. Flush and reset priority:
   - With 3 entries, flush=1 plus push=1 -> count=0, empty=1, no ovf. A new push of 8'h99 then appears on outp.
   - rst=1 with flush=1 mid-fill -> full reset state, storage zeroed.

Source files
------------

// File: rtl/reg_fifo_if.sv
// Handshake bundle for reg_fifo: write side, read side, flush and status.
interface reg_fifo_if #(
  parameter int LENGTH = 8,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              flush;
  logic [LENGTH-1:0] inp;
  logic              push;
  logic              pop;
  logic [LENGTH-1:0] outp;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic              ovf;
  logic              udf;

  modport master (
    output flush, inp, push, pop,
    input  outp, full, empty, almost_full, count, ovf, udf
  );

  modport slave (
    input  flush, inp, push, pop,
    output outp, full, empty, almost_full, count, ovf, udf
  );
endinterface

// File: rtl/reg_fifo.sv
// First-word-fall-through FIFO built from a bank of DEPTH registers.
// Head entry is visible on outp whenever the queue is non-empty; rejected
// pushes/pops are reported one cycle later on ovf/udf.
module reg_fifo #(
  parameter int LENGTH   = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input logic       clk,
  input logic       rst,
  reg_fifo_if.slave bus
);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [LENGTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              ovf_q;
  logic              udf_q;
  logic              empty_w;
  logic              full_w;
  logic              push_ok;
  logic              pop_ok;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign pop_ok  = bus.pop & ~empty_w;
  // A pop in the same cycle frees the slot a full queue would otherwise refuse.
  assign push_ok = bus.push & (~full_w | pop_ok);

  // Pointers, occupancy and error pulses; flush clears queue state but not storage.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      ovf_q   <= bus.push & ~push_ok;
      udf_q   <= bus.pop & ~pop_ok;
    end
  end

  // Storage bank: zeroed only by reset, written on an accepted push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!bus.flush && push_ok) begin
      mem[wr_ptr] <= bus.inp;
    end
  end

  // Status decodes and fall-through head, all from registered state.
  always_comb begin
    bus.empty       = empty_w;
    bus.full        = full_w;
    bus.almost_full = (count_q >= CW'(AF_LEVEL));
    bus.count       = count_q;
    bus.ovf         = ovf_q;
    bus.udf         = udf_q;
    bus.outp        = empty_w ? '0 : mem[rd_ptr];
  end
endmodule
